fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
- Pipeline control block feeding the EX-stage forwarding comparators and operand muxes.
- Tracks destination/control fields of in-flight instructions in EX, IMD (EX/MEM) and WB.
- Produces registered-state forwarding selects for both EX operands.
- Detects load-use hazards and inserts a one-cycle bubble into EX while holding IF/ID.

Parameters:
REG_W, 5, register-index width
ZERO_REG, 31, index of hardwired zero register X31; never forwarded, never a hazard source

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
Rn_ID  input  5  first source index of instruction in ID
Rm_ID  input  5  second source index of instruction in ID
UsesRm_ID  input  1  ID instruction reads Rm (0 for immediate forms)
Rd_ID  input  5  destination index of instruction in ID
RegWrite_ID  input  1  ID instruction writes register file
MemRead_ID  input  1  ID instruction is a load
flush  input  1  taken branch; squash instruction entering EX
stall_ID  output  1  hold PC and IF/ID register this cycle
FwdA  output  2  EX operand A select: 00 regfile, 01 IMD result, 10 WB result
FwdB  output  2  EX operand B select, same encoding
Rd_IMD  output  5  IMD-stage destination, to downstream comparators
Rm_EX  output  5  EX-stage Rm index, to downstream comparators
RegWrite_IMD  output  1  IMD-stage write enable, to downstream comparators

Behaviour:
- One clock; reset is synchronous and active-high. Ports named clk and reset.
- Internal stage registers:
  - EX: Rn_EX, Rm_EX, Rd_EX, RegWrite_EX, MemRead_EX.
  - IMD: Rd_IMD, RegWrite_IMD.
  - WB: Rd_WB, RegWrite_WB.
- Bubble value: all indices = ZERO_REG, RegWrite = 0, MemRead = 0.
- Reset: every stage register loads bubble; FSM -> RUN. Resulting outputs: stall_ID=0, FwdA=FwdB=00, Rd_IMD=31, Rm_EX=31, RegWrite_IMD=0.
- Reset mid-stall: reset wins; bubble everywhere next edge.
- Advance, every rising edge when not in reset:
  - IMD <- EX; WB <- IMD.
  - EX <- ID fields if stall_ID=0 and flush=0; otherwise EX <- bubble.
- Hazard term (combinational): hz = MemRead_EX & (Rd_EX != ZERO_REG) & ((Rd_EX == Rn_ID) | (UsesRm_ID & (Rd_EX == Rm_ID))).
- stall_ID = hz & ~flush & (state == RUN).
- FSM states:
  - RUN: hz & ~flush -> STALL; else stay RUN.
  - STALL: unconditionally -> RUN next edge. EX holds the bubble, so hz is 0 in this cycle.
  - stall_ID never asserts two consecutive cycles.
- Flush and hazard in same cycle: flush wins; stall_ID=0, EX <- bubble, state stays RUN.
- Forwarding, from registered state only (no ID inputs); A shown, B identical with Rm_EX:
  - FwdA=01 if RegWrite_IMD & Rd_IMD==Rn_EX & Rd_IMD!=ZERO_REG;
  - else 10 if RegWrite_WB & Rd_WB==Rn_EX & Rd_WB!=ZERO_REG;
  - else 00.
  - IMD takes priority over WB when both match.
- All REG_W bits are compared; no partial-index matches.
- Latency: ID fields appear in EX one edge after acceptance. Forward selects are valid in the same cycle the consumer is in EX.

Optional Feature:
STALL_CNT_EN
- Defined: adds output port stall_count [15:0].
  - Increments on each edge where stall_ID=1.
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset held 2 cycles with random ID inputs -> stall_ID=0, FwdA=FwdB=00, Rd_IMD=31, RegWrite_IMD=0 after release.
- ADD X3 (Rd=3, RegWrite=1) then SUB using Rn=3 -> when SUB is in EX, FwdA=01. One cycle later, if next op reads Rm=3 with UsesRm=1, FwdB=10.
- LDUR X5 (MemRead=1, Rd=5) then ADD Rn=5 -> stall_ID=1 for exactly one cycle. EX then holds bubble (RegWrite_EX=0). ADD reaches EX next with FwdA=10 (load now in WB) — check.
- Load Rd=31 followed by reader of Rn=31 -> no stall, FwdA=00. Writer Rd=31 followed by reader Rn=31 -> FwdA=00.
- Load Rd=7 and dependent ADD Rm=7, UsesRm=1, with flush=1 in that cycle -> stall_ID=0, EX bubble, state RUN. Same with UsesRm=0 and flush=0 -> no stall.
- IMD and WB both write X9, EX reads Rn=Rm=9 -> FwdA=FwdB=01. With STALL_CNT_EN, after 3 load-use stalls stall_count=3.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding select and load-use hazard control for a 5-stage pipeline.
// Optional macro STALL_CNT_EN adds a saturating 16-bit stall_count output.
module fwd_hazard_ctrl #(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] Rn_ID,
  input  logic [REG_W-1:0] Rm_ID,
  input  logic             UsesRm_ID,
  input  logic [REG_W-1:0] Rd_ID,
  input  logic             RegWrite_ID,
  input  logic             MemRead_ID,
  input  logic             flush,
  output logic             stall_ID,
  output logic [1:0]       FwdA,
  output logic [1:0]       FwdB,
  output logic [REG_W-1:0] Rd_IMD,
  output logic [REG_W-1:0] Rm_EX,
  output logic             RegWrite_IMD
`ifdef STALL_CNT_EN
  ,
  output logic [15:0]      stall_count
`endif
);

  localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

  typedef enum logic {S_RUN, S_STALL} state_t;

  state_t           r_state, w_state_nxt;
  logic [REG_W-1:0] r_rn_ex, r_rm_ex, r_rd_ex, r_rd_imd, r_rd_wb;
  logic             r_rw_ex, r_mr_ex, r_rw_imd, r_rw_wb;
  logic             w_hz, w_stall;

  assign w_hz = r_mr_ex && (r_rd_ex != ZR) &&
                ((r_rd_ex == Rn_ID) || (UsesRm_ID && (r_rd_ex == Rm_ID)));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_RUN;
    else       r_state <= w_state_nxt;
  end

  // Flush outranks the hazard: no stall and the FSM stays in RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_hz && !flush) begin
          w_stall     = 1'b1;
          w_state_nxt = S_STALL;
        end
      end
      S_STALL: w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rn_ex  <= ZR;
      r_rm_ex  <= ZR;
      r_rd_ex  <= ZR;
      r_rw_ex  <= 1'b0;
      r_mr_ex  <= 1'b0;
      r_rd_imd <= ZR;
      r_rw_imd <= 1'b0;
      r_rd_wb  <= ZR;
      r_rw_wb  <= 1'b0;
    end else begin
      if (w_stall || flush) begin
        r_rn_ex <= ZR;
        r_rm_ex <= ZR;
        r_rd_ex <= ZR;
        r_rw_ex <= 1'b0;
        r_mr_ex <= 1'b0;
      end else begin
        r_rn_ex <= Rn_ID;
        r_rm_ex <= Rm_ID;
        r_rd_ex <= Rd_ID;
        r_rw_ex <= RegWrite_ID;
        r_mr_ex <= MemRead_ID;
      end
      r_rd_imd <= r_rd_ex;
      r_rw_imd <= r_rw_ex;
      r_rd_wb  <= r_rd_imd;
      r_rw_wb  <= r_rw_imd;
    end
  end

  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] src,
    input logic [REG_W-1:0] rd_imd,
    input logic             rw_imd,
    input logic [REG_W-1:0] rd_wb,
    input logic             rw_wb
  );
    if (rw_imd && (rd_imd == src) && (rd_imd != ZR))   return 2'b01;
    else if (rw_wb && (rd_wb == src) && (rd_wb != ZR)) return 2'b10;
    else                                               return 2'b00;
  endfunction

  assign FwdA         = fwd_sel(r_rn_ex, r_rd_imd, r_rw_imd, r_rd_wb, r_rw_wb);
  assign FwdB         = fwd_sel(r_rm_ex, r_rd_imd, r_rw_imd, r_rd_wb, r_rw_wb);
  assign stall_ID     = w_stall;
  assign Rd_IMD       = r_rd_imd;
  assign Rm_EX        = r_rm_ex;
  assign RegWrite_IMD = r_rw_imd;

`ifdef STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset)                               r_stall_cnt <= '0;
    else if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign stall_count = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: pipeline-occupancy model plus directed literal checks.
module tb_fwd_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] Rn_ID, Rm_ID, Rd_ID;
  logic       UsesRm_ID, RegWrite_ID, MemRead_ID, flush;
  logic       stall_ID;
  logic [1:0] FwdA, FwdB;
  logic [4:0] Rd_IMD, Rm_EX;
  logic       RegWrite_IMD;
`ifdef STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  fwd_hazard_ctrl #(.REG_W(5), .ZERO_REG(31)) dut (
    .clk(clk), .reset(reset),
    .Rn_ID(Rn_ID), .Rm_ID(Rm_ID), .UsesRm_ID(UsesRm_ID), .Rd_ID(Rd_ID),
    .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID), .flush(flush),
    .stall_ID(stall_ID), .FwdA(FwdA), .FwdB(FwdB),
    .Rd_IMD(Rd_IMD), .Rm_EX(Rm_EX), .RegWrite_IMD(RegWrite_IMD)
`ifdef STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: queue of instructions in flight, index 0 = EX, 1 = IMD, 2 = WB.
  typedef struct packed {
    logic [4:0] rn, rm, rd;
    logic       rw, mr;
  } instr_t;

  localparam instr_t BUBBLE = '{rn: 5'd31, rm: 5'd31, rd: 5'd31, rw: 1'b0, mr: 1'b0};

  instr_t      pipe[$];
  logic        m_prev_stall = 1'b0;
  logic        m_valid      = 1'b0;
  logic [15:0] m_cnt        = '0;
  logic        m_s;
  instr_t      m_new;

  function automatic logic m_stall();
    instr_t ex;
    logic   hz;
    ex = pipe[0];
    hz = ex.mr && (ex.rd != 5'd31) &&
         ((ex.rd == Rn_ID) || (UsesRm_ID && (ex.rd == Rm_ID)));
    return hz && !flush && !m_prev_stall;
  endfunction

  // Nearest older producer wins; X31 never produces.
  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    if (src == 5'd31) return 2'b00;
    for (int k = 1; k <= 2; k++)
      if (pipe[k].rw && (pipe[k].rd == src)) return (k == 1) ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      pipe         = '{BUBBLE, BUBBLE, BUBBLE};
      m_prev_stall = 1'b0;
      m_cnt        = '0;
      m_valid      = 1'b1;
    end else if (m_valid) begin
      m_s = m_stall();
      if (m_s || flush) m_new = BUBBLE;
      else m_new = '{rn: Rn_ID, rm: Rm_ID, rd: Rd_ID, rw: RegWrite_ID, mr: MemRead_ID};
      pipe.push_front(m_new);
      void'(pipe.pop_back());
      if (m_s && (m_cnt != 16'hFFFF)) m_cnt = m_cnt + 16'd1;
      m_prev_stall = m_s;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("stall_ID",     16'(stall_ID),     16'(m_stall()));
      chk("FwdA",         16'(FwdA),         16'(m_fwd(pipe[0].rn)));
      chk("FwdB",         16'(FwdB),         16'(m_fwd(pipe[0].rm)));
      chk("Rd_IMD",       16'(Rd_IMD),       16'(pipe[1].rd));
      chk("Rm_EX",        16'(Rm_EX),        16'(pipe[0].rm));
      chk("RegWrite_IMD", 16'(RegWrite_IMD), 16'(pipe[1].rw));
`ifdef STALL_CNT_EN
      chk("stall_count",  stall_count,       m_cnt);
`endif
    end
  end

  task automatic set_id(input logic [4:0] rn, input logic [4:0] rm, input logic urm,
                        input logic [4:0] rd, input logic rw, input logic mr, input logic fl);
    Rn_ID = rn; Rm_ID = rm; UsesRm_ID = urm; Rd_ID = rd;
    RegWrite_ID = rw; MemRead_ID = mr; flush = fl;
  endtask

  task automatic id(input logic [4:0] rn, input logic [4:0] rm, input logic urm,
                    input logic [4:0] rd, input logic rw, input logic mr, input logic fl);
    @(posedge clk); #1;
    set_id(rn, rm, urm, rd, rw, mr, fl);
  endtask

  task automatic nop();
    id(5'd0, 5'd0, 1'b0, 5'd31, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [4:0] pick_reg();
    logic [1:0] r;
    r = 2'($urandom_range(0, 3));
    return (r == 2'd3) ? 5'd31 : {3'b000, r} + 5'd1;
  endfunction

  task automatic rand_id(input logic allow_flush);
    set_id(pick_reg(), pick_reg(), 1'($urandom_range(0, 1)), pick_reg(),
           1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
           allow_flush && ($urandom_range(0, 7) == 0));
  endtask

  initial begin
    reset = 1'b1;
    rand_id(1'b1);
    @(posedge clk); #1; rand_id(1'b1);
    @(posedge clk); #1; reset = 1'b0;
    set_id(5'd0, 5'd0, 1'b0, 5'd31, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_stall", 16'(stall_ID), 16'd0);
    chk("rst_FwdA", 16'(FwdA), 16'd0);
    chk("rst_FwdB", 16'(FwdB), 16'd0);
    chk("rst_Rd_IMD", 16'(Rd_IMD), 16'd31);
    chk("rst_Rm_EX", 16'(Rm_EX), 16'd31);
    chk("rst_RW_IMD", 16'(RegWrite_IMD), 16'd0);

    // ADD X3, then SUB reading X3 on Rn, then an op reading X3 on Rm
    id(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    id(5'd3, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    id(5'd8, 5'd3, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
    @(negedge clk); chk("add_sub_FwdA_IMD", 16'(FwdA), 16'd1);
    nop();
    @(negedge clk); chk("op_FwdB_WB", 16'(FwdB), 16'd2);

    // load-use on Rn: one stall, bubble, then WB forward
    id(5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    id(5'd5, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0);
    @(negedge clk); chk("ld_use_stall", 16'(stall_ID), 16'd1);
    id(5'd5, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("ld_use_no_2nd_stall", 16'(stall_ID), 16'd0);
    chk("ld_in_IMD_rd", 16'(Rd_IMD), 16'd5);
    nop();
    @(negedge clk); chk("ld_use_FwdA_WB", 16'(FwdA), 16'd2);

    // X31 as producer never stalls or forwards
    id(5'd0, 5'd0, 1'b0, 5'd31, 1'b1, 1'b1, 1'b0);
    id(5'd31, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0);
    @(negedge clk); chk("ld31_no_stall", 16'(stall_ID), 16'd0);
    id(5'd2, 5'd0, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0);
    @(negedge clk); chk("ld31_FwdA", 16'(FwdA), 16'd0);
    id(5'd31, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0);
    nop();
    @(negedge clk); chk("w31_FwdA", 16'(FwdA), 16'd0);

    // load-use on Rm squashed by flush, then Rm without UsesRm
    id(5'd0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    id(5'd1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1);
    @(negedge clk); chk("flush_beats_hz", 16'(stall_ID), 16'd0);
    nop();
    @(negedge clk);
    chk("flush_bubble_Rm_EX", 16'(Rm_EX), 16'd31);
    chk("flush_state_run", 16'(stall_ID), 16'd0);
    id(5'd0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    id(5'd2, 5'd7, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    @(negedge clk); chk("no_usesrm_no_stall", 16'(stall_ID), 16'd0);
    nop();
    @(negedge clk); chk("rm_enters_EX", 16'(Rm_EX), 16'd7);

    // IMD and WB both write X9: IMD wins on both operands
    id(5'd0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    id(5'd1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    id(5'd9, 5'd9, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    nop();
    @(negedge clk);
    chk("both_FwdA_IMD", 16'(FwdA), 16'd1);
    chk("both_FwdB_IMD", 16'(FwdB), 16'd1);

    // two more load-use stalls on Rm
    repeat (2) begin
      id(5'd0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
      id(5'd0, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
      @(negedge clk); chk("rm_ld_use_stall", 16'(stall_ID), 16'd1);
      id(5'd0, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    end
    nop();
`ifdef STALL_CNT_EN
    @(negedge clk); chk("stall_count_3", stall_count, 16'd3);
`endif

    // dense random traffic, checked by the model every cycle
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1; rand_id(1'b1);
    end

    // reset arriving during a stall cycle wins
    nop(); nop();
    id(5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    set_id(5'd5, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk); chk("rst_mid_stall_hz", 16'(stall_ID), 16'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    set_id(5'd0, 5'd0, 1'b0, 5'd31, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_mid_stall_out", 16'(stall_ID), 16'd0);
    chk("rst_mid_Rd_IMD", 16'(Rd_IMD), 16'd31);
    chk("rst_mid_RW_IMD", 16'(RegWrite_IMD), 16'd0);
`ifdef STALL_CNT_EN
    chk("rst_mid_count", stall_count, 16'd0);
`endif
    nop();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
